// File: rtl/tdr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdr_pkg
//  Description : Shared types and constants for the time-double-redundancy
//                controller: the controller state encoding, default sizing
//                and the rollback length.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdr_pkg;

    // Default sizing of a TDR domain
    localparam int N_FF_DEF      = 8;
    localparam int MAX_RETRY_DEF = 3;
    localparam int ERR_CNT_W_DEF = 8;

    // Rollback length in cycles: one cycle per register of the ff block pair
    localparam int RB_CYCLES = 2;

    // Retry counter width; wide enough for the largest MAX_RETRY (15)
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        RB0  = 3'd3,
        RB1  = 3'd4,
        HALT = 3'd5
    } tdr_state_e;

endpackage : tdr_pkg
`default_nettype wire

// File: rtl/tdr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdr_ctrl_if
//  Description : Bundle between the TDR controller, the ff block array and
//                the surrounding system.
//                master : controller side (drives mode/phase/status)
//                slave  : environment side (drives run request, fail flags)
//  Ports       : en_i, fail_i[N_FF]          environment -> controller
//                mode_s_o, phase_o, hold_in_o, out_valid_o, recover_o,
//                err_cnt_o[ERR_CNT_W], perm_fault_o   controller -> env
//  Revision    : 1.0 - initial release
// ============================================================================
interface tdr_ctrl_if #(
    parameter int N_FF      = 8,
    parameter int ERR_CNT_W = 8
) ();
    logic                 en_i;
    logic [N_FF-1:0]      fail_i;
    logic                 mode_s_o;
    logic                 phase_o;
    logic                 hold_in_o;
    logic                 out_valid_o;
    logic                 recover_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
    logic                 perm_fault_o;

    modport master (
        input  en_i, fail_i,
        output mode_s_o, phase_o, hold_in_o, out_valid_o, recover_o,
               err_cnt_o, perm_fault_o
    );

    modport slave (
        output en_i, fail_i,
        input  mode_s_o, phase_o, hold_in_o, out_valid_o, recover_o,
               err_cnt_o, perm_fault_o
    );
endinterface : tdr_ctrl_if
`default_nettype wire

// File: rtl/tdr_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Clear has priority over increment.
//  Ports       : clk, rst_n (async, active-low), inc_i, clr_i, cnt_o[WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt
    import tdr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/tdr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tdr_ctrl
//  Description : Controller for a dynamic time-double-redundancy domain.
//                Runs each period twice (P0 fresh, P1 redundant), samples the
//                OR of the ff block fail flags at the end of P1, rolls back
//                (RB0/RB1) and replays on a mismatch, and enters a sticky
//                HALT after MAX_RETRY consecutive failed periods.
//  Ports       : clk, rst_n (async, active-low)
//                bus (tdr_ctrl_if.master): en_i, fail_i, mode_s_o, phase_o,
//                hold_in_o, out_valid_o, recover_o, err_cnt_o, perm_fault_o
//  Revision    : 1.0 - initial release
// ============================================================================
module tdr_ctrl
    import tdr_pkg::*;
#(
    parameter int N_FF      = N_FF_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    tdr_ctrl_if.master bus
);

    // Retry value that, when a further failure arrives, means halt
    localparam logic [RETRY_W-1:0] LAST_RETRY = RETRY_W'(MAX_RETRY - 1);

    tdr_state_e           state_q, state_d;

    logic                 mode_s_q,  mode_s_d;
    logic                 phase_q,   phase_d;
    logic                 hold_in_q, hold_in_d;
    logic                 valid_q,   valid_d;
    logic                 recover_q, recover_d;
    logic                 perm_q,    perm_d;

    logic [N_FF-1:0]      fail_flags;
    logic                 any_fail;
    logic                 err_inc;
    logic                 retry_inc;
    logic                 retry_clr;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [ERR_CNT_W-1:0] err_cnt;

    assign fail_flags = bus.fail_i;
    assign any_fail   = |fail_flags;

    // ------------------------------------------------------------------
    // Next state. fail_i only matters on the edge that ends P1, en_i only
    // in IDLE and on P1 exit.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        err_inc   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en_i) state_d = P0;
            end
            P0: begin
                state_d = P1;
            end
            P1: begin
                if (any_fail) begin
                    err_inc   = 1'b1;
                    retry_inc = 1'b1;
                    state_d   = (retry_cnt == LAST_RETRY) ? HALT : RB0;
                end else begin
                    retry_clr = 1'b1;
                    state_d   = bus.en_i ? P0 : IDLE;
                end
            end
            RB0:     state_d = RB1;
            RB1:     state_d = P0;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so every output is a flop.
    // A P0 entered from RB1 is a replay and must keep the old input.
    // ------------------------------------------------------------------
    always_comb begin
        mode_s_d  = 1'b1;
        phase_d   = 1'b0;
        hold_in_d = 1'b1;
        recover_d = 1'b0;
        perm_d    = 1'b0;
        valid_d   = (state_q == P1) && !any_fail;
        case (state_d)
            P0: begin
                hold_in_d = (state_q == RB1);
            end
            P1: begin
                mode_s_d = 1'b0;
                phase_d  = 1'b1;
            end
            RB0, RB1: begin
                mode_s_d  = 1'b0;
                recover_d = 1'b1;
            end
            HALT: begin
                mode_s_d = 1'b0;
                perm_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_s_q  <= 1'b1;
            phase_q   <= 1'b0;
            hold_in_q <= 1'b1;
            valid_q   <= 1'b0;
            recover_q <= 1'b0;
            perm_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_s_q  <= mode_s_d;
            phase_q   <= phase_d;
            hold_in_q <= hold_in_d;
            valid_q   <= valid_d;
            recover_q <= recover_d;
            perm_q    <= perm_d;
        end
    end

    // Lifetime error count: never cleared except by reset
    sat_cnt #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (err_inc),
        .clr_i (1'b0),
        .cnt_o (err_cnt)
    );

    // Consecutive failed periods; cleared by any clean P1
    sat_cnt #(
        .WIDTH (RETRY_W)
    ) u_retry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (retry_inc),
        .clr_i (retry_clr),
        .cnt_o (retry_cnt)
    );

    assign bus.mode_s_o     = mode_s_q;
    assign bus.phase_o      = phase_q;
    assign bus.hold_in_o    = hold_in_q;
    assign bus.out_valid_o  = valid_q;
    assign bus.recover_o    = recover_q;
    assign bus.err_cnt_o    = err_cnt;
    assign bus.perm_fault_o = perm_q;

endmodule : tdr_ctrl
`default_nettype wire

// File: tb/tb_tdr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdr_ctrl
//  Description : Self-checking bench for tdr_ctrl. Instance A uses default
//                sizing (MAX_RETRY=3, ERR_CNT_W=8); instance B uses
//                ERR_CNT_W=2, MAX_RETRY=15 for counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdr_ctrl;

    logic clk;
    logic rst_na;
    logic rst_nb;

    tdr_ctrl_if #(.N_FF(8), .ERR_CNT_W(8)) ifa ();
    tdr_ctrl_if #(.N_FF(8), .ERR_CNT_W(2)) ifb ();

    tdr_ctrl #(.N_FF(8), .MAX_RETRY(3), .ERR_CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (ifa)
    );

    tdr_ctrl #(.N_FF(8), .MAX_RETRY(15), .ERR_CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Packed view of instance A outputs: {mode,phase,hold,valid,recover,perm,err[7:0]}
    typedef struct {
        logic        en;
        logic [7:0]  fail;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] ev(input logic m, input logic p, input logic h,
                                       input logic v, input logic r, input logic f,
                                       input logic [7:0] e);
        return {m, p, h, v, r, f, e};
    endfunction

    function automatic logic [13:0] act_a();
        return {ifa.mode_s_o, ifa.phase_o, ifa.hold_in_o, ifa.out_valid_o,
                ifa.recover_o, ifa.perm_fault_o, ifa.err_cnt_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_a(input logic en, input logic [7:0] fail);
        ifa.en_i   = en;
        ifa.fail_i = fail;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic en, input logic [7:0] fail);
        ifb.en_i   = en;
        ifb.fail_i = fail;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        ifa.en_i   = 1'b0;
        ifa.fail_i = 8'h00;
        rst_na     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", 32'(act_a()), 32'(ev(1, 0, 1, 0, 0, 0, 8'd0)));
        rst_na = 1'b1;
    endtask

    localparam logic [13:0] RST_V = 14'b1_0_1_0_0_0_00000000;

    vec_t vecs[25];

    initial begin
        rst_na     = 1'b0;
        rst_nb     = 1'b0;
        ifa.en_i   = 1'b0;
        ifa.fail_i = 8'h00;
        ifb.en_i   = 1'b0;
        ifb.fail_i = 8'h00;

        // ------------------------------------------------------------
        // Clean periods, single failure with fail flags on ignored
        // cycles, retry counter clearing after a clean replay.
        // ------------------------------------------------------------
        vecs[0]  = '{1'b1, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'd0)};  // P0
        vecs[1]  = '{1'b1, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd0)};  // P1
        vecs[2]  = '{1'b1, 8'h00, ev(1, 0, 0, 1, 0, 0, 8'd0)};  // P0 + valid
        vecs[3]  = '{1'b1, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd0)};
        vecs[4]  = '{1'b1, 8'h00, ev(1, 0, 0, 1, 0, 0, 8'd0)};
        vecs[5]  = '{1'b1, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd0)};
        vecs[6]  = '{1'b1, 8'h00, ev(1, 0, 0, 1, 0, 0, 8'd0)};
        vecs[7]  = '{1'b1, 8'hFF, ev(0, 1, 1, 0, 0, 0, 8'd0)};  // fail in P0 ignored
        vecs[8]  = '{1'b1, 8'h04, ev(0, 0, 1, 0, 1, 0, 8'd1)};  // RB0
        vecs[9]  = '{1'b0, 8'hFF, ev(0, 0, 1, 0, 1, 0, 8'd1)};  // RB1, fail ignored
        vecs[10] = '{1'b0, 8'hFF, ev(1, 0, 1, 0, 0, 0, 8'd1)};  // replay P0, hold=1
        vecs[11] = '{1'b0, 8'hFF, ev(0, 1, 1, 0, 0, 0, 8'd1)};  // P1
        vecs[12] = '{1'b0, 8'h00, ev(1, 0, 1, 1, 0, 0, 8'd1)};  // IDLE + valid
        vecs[13] = '{1'b0, 8'hFF, ev(1, 0, 1, 0, 0, 0, 8'd1)};  // IDLE stays
        vecs[14] = '{1'b1, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'd1)};  // fresh P0
        vecs[15] = '{1'b1, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd1)};
        vecs[16] = '{1'b1, 8'h80, ev(0, 0, 1, 0, 1, 0, 8'd2)};  // RB0
        vecs[17] = '{1'b1, 8'h00, ev(0, 0, 1, 0, 1, 0, 8'd2)};
        vecs[18] = '{1'b1, 8'h00, ev(1, 0, 1, 0, 0, 0, 8'd2)};
        vecs[19] = '{1'b1, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd2)};
        vecs[20] = '{1'b1, 8'h01, ev(0, 0, 1, 0, 1, 0, 8'd3)};  // 2nd consecutive, no halt
        vecs[21] = '{1'b0, 8'h00, ev(0, 0, 1, 0, 1, 0, 8'd3)};
        vecs[22] = '{1'b0, 8'h00, ev(1, 0, 1, 0, 0, 0, 8'd3)};
        vecs[23] = '{1'b0, 8'h00, ev(0, 1, 1, 0, 0, 0, 8'd3)};
        vecs[24] = '{1'b0, 8'h00, ev(1, 0, 1, 1, 0, 0, 8'd3)};  // IDLE + valid

        reset_a();
        for (int i = 0; i < 25; i++) begin
            step_a(vecs[i].en, vecs[i].fail);
            chk($sformatf("vec%0d", i), 32'(act_a()), 32'(vecs[i].exp));
        end

        // ------------------------------------------------------------
        // Persistent failure: three failed P1s, two rollbacks, HALT.
        // ------------------------------------------------------------
        reset_a();
        step_a(1'b1, 8'hFF);
        chk("halt_p0_first", 32'(act_a()), 32'(ev(1, 0, 0, 0, 0, 0, 8'd0)));
        for (int k = 1; k <= 3; k++) begin
            step_a(1'b1, 8'hFF);
            chk($sformatf("halt_p1_%0d", k), 32'(act_a()),
                32'(ev(0, 1, 1, 0, 0, 0, 8'(k - 1))));
            step_a(1'b1, 8'hFF);
            if (k < 3) begin
                chk($sformatf("halt_rb0_%0d", k), 32'(act_a()),
                    32'(ev(0, 0, 1, 0, 1, 0, 8'(k))));
                step_a(1'b1, 8'hFF);
                chk($sformatf("halt_rb1_%0d", k), 32'(act_a()),
                    32'(ev(0, 0, 1, 0, 1, 0, 8'(k))));
                step_a(1'b1, 8'hFF);
                chk($sformatf("halt_replay_%0d", k), 32'(act_a()),
                    32'(ev(1, 0, 1, 0, 0, 0, 8'(k))));
            end else begin
                chk("halt_entry", 32'(act_a()), 32'(ev(0, 0, 1, 0, 0, 1, 8'd3)));
            end
        end
        for (int c = 0; c < 20; c++) begin
            step_a(1'(c & 1), 8'($urandom));
            chk($sformatf("halt_hold_%0d", c), 32'(act_a()),
                32'(ev(0, 0, 1, 0, 0, 1, 8'd3)));
        end

        // ------------------------------------------------------------
        // Asynchronous reset in the middle of RB0.
        // ------------------------------------------------------------
        reset_a();
        step_a(1'b1, 8'h00);
        step_a(1'b1, 8'h00);
        step_a(1'b1, 8'hFF);
        chk("arst_in_rb0", 32'(act_a()), 32'(ev(0, 0, 1, 0, 1, 0, 8'd1)));
        #2;
        rst_na = 1'b0;
        #1;
        chk("arst_async", 32'(act_a()), 32'(RST_V));
        for (int c = 0; c < 3; c++) begin
            step_a(1'b1, 8'hFF);
            chk($sformatf("arst_held_%0d", c), 32'(act_a()), 32'(RST_V));
        end
        @(negedge clk);
        rst_na = 1'b1;
        step_a(1'b1, 8'h00);
        chk("arst_fresh_p0", 32'(act_a()), 32'(ev(1, 0, 0, 0, 0, 0, 8'd0)));
        step_a(1'b1, 8'h00);
        chk("arst_p1", 32'(act_a()), 32'(ev(0, 1, 1, 0, 0, 0, 8'd0)));
        step_a(1'b0, 8'h00);
        chk("arst_valid", 32'(act_a()), 32'(ev(1, 0, 1, 1, 0, 0, 8'd0)));

        // ------------------------------------------------------------
        // Instance B: 2-bit error counter saturates at 3, no wrap.
        // ------------------------------------------------------------
        @(negedge clk);
        rst_nb = 1'b1;
        chk("b_reset_err", 32'(ifb.err_cnt_o), 32'd0);
        step_b(1'b1, 8'h00);
        chk("b_first_p0", 32'(ifb.phase_o), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step_b(1'b1, 8'h00);                       // -> P1
            step_b(1'b1, 8'h10);                       // fail -> RB0
            chk($sformatf("b_err_%0d", k), 32'(ifb.err_cnt_o), 32'(k < 3 ? k : 3));
            chk($sformatf("b_rec_%0d", k), 32'(ifb.recover_o), 32'd1);
            step_b(1'b1, 8'h00);                       // -> RB1
            step_b(1'b1, 8'h00);                       // -> replay P0
            step_b(1'b1, 8'h00);                       // -> P1
            step_b(1'b1, 8'h00);                       // clean -> P0
            chk($sformatf("b_valid_replay_%0d", k), 32'(ifb.out_valid_o), 32'd1);
            step_b(1'b1, 8'h00);                       // -> P1
            step_b(1'b1, 8'h00);                       // clean -> P0
            chk($sformatf("b_valid_clean_%0d", k), 32'(ifb.out_valid_o), 32'd1);
            chk($sformatf("b_noperm_%0d", k), 32'(ifb.perm_fault_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tdr_ctrl
`default_nettype wire

// File: doc/tdr_ctrl.md
Name: tdr_ctrl

Overview:
- Controller for a dynamic time-double-redundancy (TDR) domain built from self-recovering double-register flip-flop blocks.
- Drives the shared mode-select line to every ff block and collects their per-block fail flags.
- Sequences the two redundant execution phases, and rolls back and replays on a detected mismatch.
- Escalates to a sticky permanent-fault halt after repeated failures. Sits directly above the ff block array; its outputs also gate input acceptance and output validity towards the surrounding system.

Parameters:
N_FF, 8, number of ff blocks whose fail flags are collected
MAX_RETRY, 3, consecutive failed periods tolerated before halt (range 1..15)
ERR_CNT_W, 8, width of the lifetime error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_i  input  1  run request for the protected circuit
fail_i  input  N_FF  fail flags from the ff blocks, one bit per block
mode_s_o  output  1  mode select to all ff blocks; 1 = fresh copy, 0 = saved copy
phase_o  output  1  0 = first execution, 1 = redundant execution
hold_in_o  output  1  1 = environment must keep presenting the previous period's input
out_valid_o  output  1  one-cycle strobe: the period just completed is verified
recover_o  output  1  high while rollback is in progress
err_cnt_o  output  ERR_CNT_W  saturating count of detected failures since reset
perm_fault_o  output  1  sticky permanent-fault flag

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered (Moore).
- Reset values:
  - State: IDLE.
  - mode_s_o=1, phase_o=0, hold_in_o=1.
  - out_valid_o=0, recover_o=0, err_cnt_o=0, perm_fault_o=0.
  - Internal retry counter = 0.
- Reset asserted mid-period aborts immediately to the reset values. No partial period completes.
- States and transitions:
  - IDLE: mode_s_o=1, hold_in_o=1. If en_i=1, go to P0 next cycle.
  - P0: mode_s_o=1, phase_o=0, hold_in_o=0 on a fresh period and 1 on a replay period. Unconditionally go to P1.
  - P1: mode_s_o=0, phase_o=1, hold_in_o=1. At the edge ending P1, sample any_fail = OR of all fail_i bits.
    - any_fail=0: clear the retry counter; assert out_valid_o for exactly the next cycle. Go to P0 if en_i=1, else IDLE.
    - any_fail=1: increment err_cnt_o (saturating at all-ones; no wrap) and increment the retry counter. If the retry counter reaches MAX_RETRY, go to HALT; otherwise go to RB0.
  - RB0 and RB1: mode_s_o=0, recover_o=1, hold_in_o=1 (2-cycle rollback that reloads both ff registers from the saved copy). RB0 goes to RB1. RB1 goes to P0, marked as a replay, which forces hold_in_o=1 in that P0.
  - HALT: perm_fault_o=1, mode_s_o=0, hold_in_o=1, out_valid_o=0. Exit only by reset.
- fail_i is ignored in every state except the sample at the end of P1.
- en_i is sampled only in IDLE and at P1 exit. A started P0/P1 pair always completes. A rollback/replay runs regardless of en_i.
- Latency and throughput:
  - A clean period takes 2 cycles; out_valid_o rises on the cycle after P1.
  - A single failure costs 4 extra cycles (RB0, RB1, P0, P1) before out_valid_o.
  - Back-to-back clean periods give out_valid_o every 2nd cycle.
- A retry counter of MAX_RETRY is reachable only on the entry to HALT. The counter never wraps.

Decomposition:
- Package tdr_pkg:
  - State enum: IDLE, P0, P1, RB0, RB1, HALT.
  - Default constants for N_FF, MAX_RETRY and ERR_CNT_W.
  - RB_CYCLES = 2.
- One sub-module, sat_cnt: parameterised-width saturating counter with inc and clr inputs. Instantiated twice: once for err_cnt_o and once for the retry counter.

Test Plan:
1. Reset, then en_i=1 with fail_i=0 for 6 cycles -> phase_o toggles 0,1,0,1,0,1; mode_s_o=1,0,1,0,1,0; out_valid_o high on cycles 3 and 5; err_cnt_o=0.
2. Single failure: fail_i=8'h04 during P1 of the first period -> err_cnt_o=1; recover_o high 2 cycles; replay P0 has hold_in_o=1; out_valid_o 4 cycles later than in the clean case; retry counter cleared after the clean P1.
3. fail_i=8'hFF in every P1 with MAX_RETRY=3 -> three P1 failures, two rollbacks, then HALT; perm_fault_o=1 stays high 20 cycles while en_i toggles; err_cnt_o=3.
4. fail_i pulsed only during P0, RB0 and RB1 -> ignored; err_cnt_o stays 0; out_valid_o on schedule.
5. ERR_CNT_W=2, MAX_RETRY=15, fail on alternating periods 6 times -> err_cnt_o saturates at 3 and never wraps to 0.
6. rst_n low in the middle of RB0, released 3 cycles later -> all outputs at reset values asynchronously; IDLE; the next en_i starts a fresh P0 with hold_in_o=0.
